// File: rtl/lights_pkg.sv
// Shared types and LED pattern constants for the wind-lights FSM and its mode detector.
package lights_pkg;

  localparam int unsigned PAT_W = 3;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    MODE_CALM = 2'b00,
    MODE_R2L  = 2'b01,
    MODE_L2R  = 2'b10,
    MODE_UNK  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEARCH = 2'b01,
    LOCKED = 2'b10
  } det_state_t;

  localparam logic [PAT_W-1:0] PAT_L    = 3'b100;
  localparam logic [PAT_W-1:0] PAT_C    = 3'b010;
  localparam logic [PAT_W-1:0] PAT_R    = 3'b001;
  localparam logic [PAT_W-1:0] PAT_CALM = 3'b101;

  // A pattern the lights FSM can actually drive.
  function automatic logic pat_legal(input logic [PAT_W-1:0] p);
    return (p == PAT_L) || (p == PAT_C) || (p == PAT_R) || (p == PAT_CALM);
  endfunction

endpackage

// File: rtl/lights_trans_classify.sv
// Combinational classifier of one LED step prev->cur into a lights mode, or bad.
module lights_trans_classify
  import lights_pkg::*;
(
  input  logic [PAT_W-1:0] i_prev,
  input  logic [PAT_W-1:0] i_cur,
  output mode_t            o_cls_c,
  output logic             o_bad_c
);

  always_comb begin
    o_cls_c = MODE_UNK;
    o_bad_c = 1'b1;
    case ({i_prev, i_cur})
      {PAT_CALM, PAT_C}, {PAT_C, PAT_CALM}: begin
        o_cls_c = MODE_CALM;
        o_bad_c = 1'b0;
      end
      {PAT_R, PAT_C}, {PAT_C, PAT_L}, {PAT_L, PAT_R}: begin
        o_cls_c = MODE_R2L;
        o_bad_c = 1'b0;
      end
      {PAT_L, PAT_C}, {PAT_C, PAT_R}, {PAT_R, PAT_L}: begin
        o_cls_c = MODE_L2R;
        o_bad_c = 1'b0;
      end
      default: begin
        o_cls_c = MODE_UNK;
        o_bad_c = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lights_mode_detector.sv
// Recovers the wind-lights mode from the observed LED stream and reports lock/err.
// Optional LIGHTS_DET_HOLD_EN: a repeated legal pattern is a stall instead of an error.
module lights_mode_detector
  import lights_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [PAT_W-1:0] leds,
  output logic [1:0]       mode,
  output logic             locked,
  output logic             err
);

  localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_COUNT);

  det_state_t       r_state;
  logic [PAT_W-1:0] r_prev;
  logic             r_prev_valid;
  logic [CNT_W-1:0] r_cnt;
  mode_t            r_cand;
  mode_t            r_mode;
  logic             r_locked;
  logic             r_err;

  mode_t            w_cls;
  logic             w_bad;
  logic             w_cur_legal;
  logic             w_stall;
  logic [CNT_W-1:0] w_cnt_inc;

  lights_trans_classify u_classify (
    .i_prev  (r_prev),
    .i_cur   (leds),
    .o_cls_c (w_cls),
    .o_bad_c (w_bad)
  );

  assign w_cur_legal = pat_legal(leds);
  assign w_cnt_inc   = r_cnt + CNT_W'(1);

`ifdef LIGHTS_DET_HOLD_EN
  // A slow lights FSM shows the same legal pattern for several samples.
  assign w_stall = r_prev_valid && w_cur_legal && (leds == r_prev);
`else
  assign w_stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_cnt        <= '0;
      r_cand       <= MODE_UNK;
      r_mode       <= MODE_UNK;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (sample_en && !w_stall) begin
        case (r_state)
          IDLE: begin
            if (w_cur_legal) begin
              r_prev       <= leds;
              r_prev_valid <= 1'b1;
              r_cnt        <= '0;
              r_state      <= SEARCH;
            end else begin
              r_err <= 1'b1;
            end
          end

          SEARCH: begin
            r_prev <= leds;
            if (w_bad) begin
              r_err <= 1'b1;
              r_cnt <= '0;
              if (!w_cur_legal) begin
                r_state      <= IDLE;
                r_prev_valid <= 1'b0;
              end
            end else if ((r_cnt != '0) && (w_cls == r_cand)) begin
              if (w_cnt_inc >= LOCK_N) begin
                r_cnt    <= LOCK_N;
                r_mode   <= r_cand;
                r_locked <= 1'b1;
                r_state  <= LOCKED;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              // New candidate; a single-transition lock needs no confirmation.
              r_cand <= w_cls;
              r_cnt  <= CNT_W'(1);
              if (LOCK_N == CNT_W'(1)) begin
                r_mode   <= w_cls;
                r_locked <= 1'b1;
                r_state  <= LOCKED;
              end
            end
          end

          LOCKED: begin
            r_prev <= leds;
            if (w_bad || (w_cls != r_mode)) begin
              r_err    <= 1'b1;
              r_locked <= 1'b0;
              r_mode   <= MODE_UNK;
              if (!w_cur_legal) begin
                r_cnt        <= '0;
                r_prev_valid <= 1'b0;
                r_state      <= IDLE;
              end else if (w_bad) begin
                r_cnt   <= '0;
                r_state <= SEARCH;
              end else begin
                r_cand  <= w_cls;
                r_cnt   <= CNT_W'(1);
                r_state <= SEARCH;
              end
            end
          end

          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign mode   = r_mode;
  assign locked = r_locked;
  assign err    = r_err;

endmodule

// File: doc/lights_mode_detector.md
Name: lights_mode_detector

Overview:
- Receive-side counterpart of the wind-lights FSM. Watches the 3-bit LED pattern stream that FSM drives and recovers the selected mode: calm, right-to-left or left-to-right.
- Sits beside the lights FSM in DE1_SoC on the same divided clock, with the lights FSM output wired to leds.
- Used as an on-board self-check of the light sequence and as a reusable pattern checker in benches.

Parameters:
- LOCK_COUNT, 2: number of consecutive consistent transitions required before locked asserts; legal range 1..7.

Ports:
- clk  input  1  system clock (divided clock on board, CLOCK_50 in simulation).
- reset  input  1  synchronous, active-low; reset==0 on a clk rising edge clears all state.
- sample_en  input  1  qualifies leds; one strobe per lights step (tie to 1 when the lights FSM shares clk).
- leds  input  3  observed pattern; bit 2 = leftmost LED.
- mode  output  2  00 calm, 01 right-to-left, 10 left-to-right, 11 unknown.
- locked  output  1  mode is trustworthy.
- err  output  1  one-cycle pulse on an illegal pattern or transition.

Behaviour:
- All outputs are registered. Reset values: mode=11, locked=0, err=0, prev=000, prev_valid=0, match_cnt=0, state=IDLE.
- Transition classification of prev->cur. Only transitions with sample_en=1 are evaluated.
  - CALM: 101->010, 010->101.
  - R2L: 001->010, 010->100, 100->001.
  - L2R: 100->010, 010->001, 001->100.
  - Anything else is BAD. This includes any pattern in {000, 011, 110, 111} and a repeated identical pattern.
- Legal pattern set is {001, 010, 100, 101}.
- States:
  - IDLE: no previous sample. On sample_en with a legal leds: store prev, go to SEARCH. On sample_en with an illegal leds: err pulse, stay in IDLE.
  - SEARCH: evaluate each class.
    - Class equals cand with match_cnt+1 == LOCK_COUNT: go to LOCKED, mode=cand, locked=1.
    - Class equals cand otherwise: match_cnt++.
    - Class differs and is not BAD: cand=class, match_cnt=1 (goes straight to LOCKED when LOCK_COUNT==1).
    - BAD: err pulse, match_cnt=0. Go to IDLE if cur is illegal; otherwise stay in SEARCH with prev=cur.
  - LOCKED: class equals mode: hold.
    - Any other class, including BAD: err pulse, locked=0, mode=11.
    - Then load cand=class, match_cnt=1, go to SEARCH; if cur is illegal, go to IDLE instead.
- prev is updated to cur on every sample_en in SEARCH and LOCKED.
- Latency: outputs reflect a sample on the clk edge after the edge where sample_en=1 was sampled.
- Lock time from IDLE: LOCK_COUNT+1 samples.
- sample_en=0: all state holds, err=0.
- reset==0 overrides sample_en; reset mid-lock returns to the reset values on the next edge.
- match_cnt saturates at LOCK_COUNT and never wraps.

Optional Feature:
- Macro: LIGHTS_DET_HOLD_EN.
- Defined: a repeated identical legal pattern is treated as a stall. State and outputs hold, no err, match_cnt unchanged. This tolerates a lights FSM clocked slower than sample_en.
- Undefined: a repeat is BAD, as specified above.

Decomposition:
- Package lights_pkg holds:
  - typedef enum logic [1:0] mode_t {MODE_CALM=2'b00, MODE_R2L=2'b01, MODE_L2R=2'b10, MODE_UNK=2'b11}.
  - Pattern constants PAT_L=3'b100, PAT_C=3'b010, PAT_R=3'b001, PAT_CALM=3'b101.
  - typedef enum for detector state {IDLE, SEARCH, LOCKED}.
- The lights FSM reuses mode_t and the pattern constants.
- One sub-module: lights_trans_classify, a combinational function of (prev, cur) returning mode_t plus a bad flag.

Test Plan (sample_en=1 unless stated, LOCK_COUNT=2):
- Reset then leds 101,010,101: locked=1 and mode=00 on the edge after the third sample; err never pulses.
- Leds 001,010,100,001: locks mode=01 after 100; holds through 001.
- Locked L2R (100,010,001), then inject 011: err=1 for one cycle, locked=0, mode=11, state IDLE; then 100,010,001 relocks mode=10.
- Locked calm, then 010->100 (R2L class): err pulse, unlock; next 001 relocks mode=01 (LOCK_COUNT=2).
- Locked R2L, sample_en=0 for 5 cycles with leds changing arbitrarily: outputs unchanged, no err. Then reset=0 for one edge: mode=11, locked=0.
- Repeat 010,010: err pulse without LIGHTS_DET_HOLD_EN; no err and state held with it.
